// File: rtl/axi_stream_slave.sv
// AXI-Stream receive stage: small show-ahead FIFO with registered TREADY,
// per-word TLAST storage and a wrapping count of frames consumed downstream.
module axi_stream_slave #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  parameter int FDATA = 32
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [FDATA-1:0]         TDATA,
  input  logic                     TVALID,
  input  logic                     TLAST,
  output logic                     TREADY,
  output logic [FDATA-1:0]         rgb_out,
  output logic                     rgb_last,
  output logic                     rgb_valid,
  input  logic                     rgb_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         frame_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [FDATA:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]    count_reg, count_next;
  logic [CNT_W-1:0] frame_count_reg, frame_count_next;
  logic             ready_en_reg;

  logic             push, pop, full, empty;
  logic [FDATA:0]   head;

  assign full  = (count_reg == LW'(DEPTH));
  assign empty = (count_reg == '0);

  // TREADY is built only from flops, so upstream never sees a path through this stage.
  assign TREADY    = ready_en_reg & ~full;
  assign rgb_valid = ~empty;
  assign push      = TVALID & TREADY;
  assign pop       = rgb_valid & rgb_ready;

  // Output is gated while empty so uninitialised storage never shows.
  assign head       = mem[rd_ptr_reg];
  assign rgb_out    = empty ? '0 : head[FDATA-1:0];
  assign rgb_last   = ~empty & head[FDATA];
  assign fifo_level = count_reg;
  assign frame_count = frame_count_reg;

  always_comb begin
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    count_next       = count_reg;
    frame_count_next = frame_count_reg;
    if (push)
      wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop)
      rd_ptr_next = rd_ptr_reg + AW'(1);
    case ({push, pop})
      2'b10:   count_next = count_reg + LW'(1);
      2'b01:   count_next = count_reg - LW'(1);
      default: count_next = count_reg;
    endcase
    if (pop && head[FDATA])
      frame_count_next = frame_count_reg + CNT_W'(1);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      frame_count_reg <= '0;
      ready_en_reg    <= 1'b0;
    end else begin
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      count_reg       <= count_next;
      frame_count_reg <= frame_count_next;
      ready_en_reg    <= 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push)
      mem[wr_ptr_reg] <= {TLAST, TDATA};
  end

endmodule
